// File: rtl/mux_bank_bbm_if.sv
// Bus bundle for mux_bank_bbm: channel words, disable, select request and status.
interface mux_bank_bbm_if #(
   parameter int WIDTH    = 4,
   parameter int CHANNELS = 2,
   parameter int SELW     = $clog2(CHANNELS)
);
   logic [CHANNELS*WIDTH-1:0] d;
   logic                      E;
   logic [SELW-1:0]           sel;
   logic                      sel_load;
   logic [WIDTH-1:0]          Y;
   logic [SELW-1:0]           active_ch;
   logic                      busy;
   logic                      sel_err;

   modport master (
      output d, E, sel, sel_load,
      input  Y, active_ch, busy, sel_err
   );

   modport slave (
      input  d, E, sel, sel_load,
      output Y, active_ch, busy, sel_err
   );
endinterface

// File: rtl/mux_bank_bbm.sv
// Registered CHANNELS:1 word multiplexer with active-high disable and a
// break-before-make dead gap of DEAD zero cycles on every channel change.
module mux_bank_bbm #(
   parameter int WIDTH    = 4,
   parameter int CHANNELS = 2,
   parameter int DEAD     = 1,
   parameter int SELW     = $clog2(CHANNELS)
) (
   input logic         clk,
   input logic         rst,
   mux_bank_bbm_if.slave bus
);
   // Counter holds DEAD-1 at most; keep at least one bit so DEAD=0 still elaborates.
   localparam int CNTW = (DEAD > 0) ? $clog2(DEAD + 1) : 1;

   localparam logic [0:0] RUN = 1'b0;
   localparam logic [0:0] GAP = 1'b1;

   logic [CHANNELS-1:0][WIDTH-1:0] words;
   logic [0:0]      state;
   logic [CNTW-1:0] cnt;
   logic [SELW-1:0] pend;
   logic [SELW-1:0] active_ch;
   logic [WIDTH-1:0] y_q;
   logic            sel_err_q;
   logic            sel_ok;
   logic            switch_req;
   logic            err_req;

   assign words = bus.d;

   // Classify the select request; only RUN looks at sel_load at all.
   always_comb begin
      sel_ok     = 32'(bus.sel) < CHANNELS;
      switch_req = (state == RUN) && bus.sel_load && sel_ok && (bus.sel != active_ch);
      err_req    = (state == RUN) && bus.sel_load && !sel_ok;
   end

   // RUN/GAP sequencer and registered output word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RUN;
         cnt       <= '0;
         pend      <= '0;
         active_ch <= '0;
         y_q       <= '0;
         sel_err_q <= 1'b0;
      end else begin
         sel_err_q <= err_req;
         case (state)
            RUN: begin
               if (switch_req) begin
                  if (DEAD == 0) begin
                     // No gap: make the new connection on this very edge.
                     active_ch <= bus.sel;
                     y_q       <= bus.E ? '0 : words[bus.sel];
                  end else begin
                     // Break now; the old channel stays reported until exit.
                     pend  <= bus.sel;
                     cnt   <= CNTW'(DEAD - 1);
                     state <= GAP;
                     y_q   <= '0;
                  end
               end else begin
                  y_q <= bus.E ? '0 : words[active_ch];
               end
            end
            default: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNTW'(1);
                  y_q <= '0;
               end else begin
                  active_ch <= pend;
                  state     <= RUN;
                  y_q       <= bus.E ? '0 : words[pend];
               end
            end
         endcase
      end
   end

   assign bus.Y         = y_q;
   assign bus.active_ch = active_ch;
   assign bus.busy      = (state == GAP);
   assign bus.sel_err   = sel_err_q;
endmodule

// File: tb/tb_mux_bank_bbm.sv
// Scoreboard bench for mux_bank_bbm: three configurations share one clock;
// expectations are queued per cycle and popped after the edge.
module tb_mux_bank_bbm;
   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   // u0: 2 channels, DEAD=2; u1: 3 channels, DEAD=1; u2: 2 channels, DEAD=0
   mux_bank_bbm_if #(.WIDTH(4), .CHANNELS(2)) if0 ();
   mux_bank_bbm_if #(.WIDTH(4), .CHANNELS(3)) if1 ();
   mux_bank_bbm_if #(.WIDTH(4), .CHANNELS(2)) if2 ();

   mux_bank_bbm #(.WIDTH(4), .CHANNELS(2), .DEAD(2)) u0 (.clk(clk), .rst(rst), .bus(if0));
   mux_bank_bbm #(.WIDTH(4), .CHANNELS(3), .DEAD(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
   mux_bank_bbm #(.WIDTH(4), .CHANNELS(2), .DEAD(0)) u2 (.clk(clk), .rst(rst), .bus(if2));

   typedef struct {
      int         inst;
      string      tag;
      logic [3:0] y;
      logic [1:0] ach;
      logic       busy;
      logic       err;
   } exp_t;

   typedef struct packed {
      logic [3:0] y;
      logic [1:0] ach;
      logic       busy;
      logic       err;
   } obs_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic obs_t observe(input int inst);
      obs_t o;
      case (inst)
         0:       begin o.y = if0.Y; o.ach = 2'(if0.active_ch); o.busy = if0.busy; o.err = if0.sel_err; end
         1:       begin o.y = if1.Y; o.ach = if1.active_ch;     o.busy = if1.busy; o.err = if1.sel_err; end
         default: begin o.y = if2.Y; o.ach = 2'(if2.active_ch); o.busy = if2.busy; o.err = if2.sel_err; end
      endcase
      return o;
   endfunction

   task automatic cmp_state(input int inst, input string tag, input logic [3:0] y,
                            input logic [1:0] ach, input logic b, input logic e);
      obs_t o;
      o = observe(inst);
      chk({tag, ".Y"},    int'(o.y),    int'(y));
      chk({tag, ".ach"},  int'(o.ach),  int'(ach));
      chk({tag, ".busy"}, int'(o.busy), int'(b));
      chk({tag, ".err"},  int'(o.err),  int'(e));
   endtask

   // Queue the expected post-edge state for the inputs already driven, clock once, then drain.
   task automatic cyc(input int inst, input string tag, input logic [3:0] y,
                      input logic [1:0] ach, input logic b, input logic e);
      exp_t x;
      x.inst = inst; x.tag = tag; x.y = y; x.ach = ach; x.busy = b; x.err = e;
      sb.push_back(x);
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         x = sb.pop_front();
         cmp_state(x.inst, x.tag, x.y, x.ach, x.busy, x.err);
      end
   endtask

   initial begin
      if0.d = {4'hA, 4'h5}; if0.E = 1'b0; if0.sel = '0; if0.sel_load = 1'b0;
      if1.d = {4'h7, 4'hA, 4'h5}; if1.E = 1'b0; if1.sel = '0; if1.sel_load = 1'b0;
      if2.d = {4'hA, 4'h5}; if2.E = 1'b0; if2.sel = '0; if2.sel_load = 1'b0;

      // reset state, held across an edge
      #12;
      cmp_state(0, "rst0", 4'h0, 2'd0, 1'b0, 1'b0);
      cmp_state(1, "rst1", 4'h0, 2'd0, 1'b0, 1'b0);
      cmp_state(2, "rst2", 4'h0, 2'd0, 1'b0, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;

      // u0 steady state and disable
      cyc(0, "run5", 4'h5, 2'd0, 1'b0, 1'b0);
      if0.E = 1'b1;
      cyc(0, "dis", 4'h0, 2'd0, 1'b0, 1'b0);
      if0.E = 1'b0;
      cyc(0, "run5b", 4'h5, 2'd0, 1'b0, 1'b0);

      // break-before-make with a retarget attempt in the gap
      if0.sel_load = 1'b1; if0.sel = 1'b1;
      cyc(0, "gap_t", 4'h0, 2'd0, 1'b1, 1'b0);
      if0.sel = 1'b0;
      cyc(0, "gap_t1", 4'h0, 2'd0, 1'b1, 1'b0);
      if0.sel_load = 1'b0;
      cyc(0, "make1", 4'hA, 2'd1, 1'b0, 1'b0);

      // request for the already-connected channel: no gap
      if0.sel_load = 1'b1; if0.sel = 1'b1;
      cyc(0, "same", 4'hA, 2'd1, 1'b0, 1'b0);
      if0.sel_load = 1'b0;
      cyc(0, "same2", 4'hA, 2'd1, 1'b0, 1'b0);

      // disable during gap and on the exit edge
      if0.sel_load = 1'b1; if0.sel = 1'b0;
      cyc(0, "egap0", 4'h0, 2'd1, 1'b1, 1'b0);
      if0.sel_load = 1'b0; if0.E = 1'b1;
      cyc(0, "egap1", 4'h0, 2'd1, 1'b1, 1'b0);
      cyc(0, "eexit", 4'h0, 2'd0, 1'b0, 1'b0);
      if0.E = 1'b0;
      cyc(0, "run5c", 4'h5, 2'd0, 1'b0, 1'b0);
      if0.d = {4'h3, 4'hC};
      cyc(0, "newd", 4'hC, 2'd0, 1'b0, 1'b0);

      // reset mid-gap discards the pending channel
      if0.sel_load = 1'b1; if0.sel = 1'b1;
      cyc(0, "pre_rst", 4'h0, 2'd0, 1'b1, 1'b0);
      if0.sel_load = 1'b0;
      rst = 1'b1;
      #1;
      cmp_state(0, "midrst", 4'h0, 2'd0, 1'b0, 1'b0);
      #2;
      rst = 1'b0;
      cyc(0, "post_rst", 4'hC, 2'd0, 1'b0, 1'b0);
      cyc(0, "post_rst2", 4'hC, 2'd0, 1'b0, 1'b0);
      cyc(0, "post_rst3", 4'hC, 2'd0, 1'b0, 1'b0);

      // u1: out-of-range request, then a valid 1-cycle gap
      cyc(1, "c3run", 4'h5, 2'd0, 1'b0, 1'b0);
      if1.sel_load = 1'b1; if1.sel = 2'd3;
      cyc(1, "oor", 4'h5, 2'd0, 1'b0, 1'b1);
      if1.sel_load = 1'b0;
      cyc(1, "oor_clr", 4'h5, 2'd0, 1'b0, 1'b0);
      if1.sel_load = 1'b1; if1.sel = 2'd2;
      cyc(1, "c3gap", 4'h0, 2'd0, 1'b1, 1'b0);
      if1.sel = 2'd3;
      cyc(1, "c3exit", 4'h7, 2'd2, 1'b0, 1'b0);
      cyc(1, "oor2", 4'h7, 2'd2, 1'b0, 1'b1);
      if1.sel_load = 1'b0;
      cyc(1, "oor2_clr", 4'h7, 2'd2, 1'b0, 1'b0);

      // u2: DEAD=0 switches on the same edge, busy never rises
      cyc(2, "d0run", 4'h5, 2'd0, 1'b0, 1'b0);
      if2.sel_load = 1'b1; if2.sel = 1'b1;
      cyc(2, "d0sw1", 4'hA, 2'd1, 1'b0, 1'b0);
      if2.sel = 1'b0; if2.E = 1'b1;
      cyc(2, "d0sw0e", 4'h0, 2'd0, 1'b0, 1'b0);
      if2.sel_load = 1'b0; if2.E = 1'b0;
      cyc(2, "d0run2", 4'h5, 2'd0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
